// File: rtl/dsp_console.sv
// dsp_console: turns a byte stream of characters into display write cycles.
// It keeps a text cursor, handles CR/LF and line wrap, and scrolls the screen
// by copying each row up one line and then blanking the bottom row.
module dsp_console #(
  parameter int          ROWS  = 30,
  parameter int          COLS  = 80,
  parameter logic [7:0]  ATTR  = 8'h07,
  parameter logic [7:0]  BLANK = 8'h20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        busy,
  output logic [11:0] dsp_addr,
  output logic        dsp_en,
  output logic        dsp_wr,
  input  logic        dsp_wt,
  output logic [15:0] dsp_wdata,
  input  logic [15:0] dsp_rdata
);

  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  // Source row of the final copy pair; only meaningful when ROWS > 1.
  localparam logic [4:0]  COPY_END = 5'(ROWS - 2);
  localparam logic [15:0] BLANK_W  = {ATTR, BLANK};
  localparam logic [7:0]  CH_CR    = 8'h0D;
  localparam logic [7:0]  CH_LF    = 8'h0A;

  // CLEAR emits the write at (sr,sc) on each edge. SC_RD / SC_WR / FILL name
  // the bus cycle currently on the outputs and pick the next one.
  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_SC_GO, S_SC_RD, S_SC_WR, S_FILL
  } state_t;

  state_t      state_q, state_d;
  logic [4:0]  row_q, row_d, sr_q, sr_d;
  logic [6:0]  col_q, col_d, sc_q, sc_d;
  logic        en_q, en_d, wr_q, wr_d, rdy_q, rdy_d, busy_q;
  logic [11:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        nl;

  // Next-state and next-output decode; all outputs come straight from flops.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    sr_d    = sr_q;
    sc_d    = sc_q;
    en_d    = 1'b0;
    wr_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdy_d   = 1'b0;
    nl      = 1'b0;
    case (state_q)
      S_CLEAR: begin
        en_d    = 1'b1;
        wr_d    = 1'b1;
        addr_d  = {sr_q, sc_q};
        wdata_d = BLANK_W;
        if (sc_q == LAST_COL) begin
          sc_d = '0;
          if (sr_q == LAST_ROW) begin
            sr_d    = '0;
            row_d   = '0;
            col_d   = '0;
            state_d = S_IDLE;
          end else begin
            sr_d = sr_q + 5'd1;
          end
        end else begin
          sc_d = sc_q + 7'd1;
        end
      end
      S_IDLE: begin
        rdy_d = 1'b1;
        if (in_valid && rdy_q) begin
          rdy_d = 1'b0;
          if (in_data == CH_CR) begin
            col_d = '0;
          end else if (in_data == CH_LF) begin
            col_d = '0;
            nl    = 1'b1;
          end else begin
            en_d    = 1'b1;
            wr_d    = 1'b1;
            addr_d  = {row_q, col_q};
            wdata_d = {ATTR, in_data};
            if (col_q == LAST_COL) begin
              col_d = '0;
              nl    = 1'b1;
            end else begin
              col_d = col_q + 7'd1;
            end
          end
          // Newline on the bottom row scrolls instead of moving the cursor.
          if (nl) begin
            if (row_q == LAST_ROW) state_d = S_SC_GO;
            else                   row_d   = row_q + 5'd1;
          end
        end
      end
      S_SC_GO: begin
        sr_d = '0;
        sc_d = '0;
        en_d = 1'b1;
        if (ROWS > 1) begin
          addr_d  = {5'd1, 7'd0};
          state_d = S_SC_RD;
        end else begin
          wr_d    = 1'b1;
          addr_d  = {LAST_ROW, 7'd0};
          wdata_d = BLANK_W;
          state_d = S_FILL;
        end
      end
      S_SC_RD: begin
        // Hold the read until the responder stops waiting, then write it up.
        en_d = 1'b1;
        if (!dsp_wt) begin
          wr_d    = 1'b1;
          addr_d  = {sr_q, sc_q};
          wdata_d = dsp_rdata;
          state_d = S_SC_WR;
        end
      end
      S_SC_WR: begin
        en_d = 1'b1;
        if (sc_q == LAST_COL) begin
          sc_d = '0;
          if (sr_q == COPY_END) begin
            wr_d    = 1'b1;
            addr_d  = {LAST_ROW, 7'd0};
            wdata_d = BLANK_W;
            state_d = S_FILL;
          end else begin
            sr_d    = sr_q + 5'd1;
            addr_d  = {sr_q + 5'd2, 7'd0};
            state_d = S_SC_RD;
          end
        end else begin
          sc_d    = sc_q + 7'd1;
          addr_d  = {sr_q + 5'd1, sc_q + 7'd1};
          state_d = S_SC_RD;
        end
      end
      S_FILL: begin
        if (sc_q == LAST_COL) begin
          sc_d    = '0;
          rdy_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          sc_d    = sc_q + 7'd1;
          en_d    = 1'b1;
          wr_d    = 1'b1;
          addr_d  = {LAST_ROW, sc_q + 7'd1};
          wdata_d = BLANK_W;
        end
      end
      default: state_d = S_CLEAR;
    endcase
  end

  // State and output registers; reset abandons any operation and restarts CLEAR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_CLEAR;
      row_q   <= '0;
      col_q   <= '0;
      sr_q    <= '0;
      sc_q    <= '0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdy_q   <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      sr_q    <= sr_d;
      sc_q    <= sc_d;
      en_q    <= en_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdy_q   <= rdy_d;
      busy_q  <= ~rdy_d;
    end
  end

  assign in_ready  = rdy_q;
  assign busy      = busy_q;
  assign dsp_en    = en_q;
  assign dsp_wr    = wr_q;
  assign dsp_addr  = addr_q;
  assign dsp_wdata = wdata_q;

endmodule

// File: tb/tb_dsp_console.sv
// Directed bench for dsp_console: clear, typing, wrap, CR/LF, scroll, reset
// during a scroll read, and idle behaviour. The responder returns {4'hA,addr}
// on reads and holds wt for the first cycle of each read.
module tb_dsp_console;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready, busy, dsp_en, dsp_wr, dsp_wt;
  logic [11:0] dsp_addr;
  logic [15:0] dsp_wdata, dsp_rdata;
  logic        wt_done;

  int n_vec = 0;
  int n_bad = 0;

  dsp_console dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .busy(busy), .dsp_addr(dsp_addr), .dsp_en(dsp_en),
    .dsp_wr(dsp_wr), .dsp_wt(dsp_wt), .dsp_wdata(dsp_wdata), .dsp_rdata(dsp_rdata)
  );

  always #5 clk = ~clk;

  // Responder: wait for exactly the first cycle of a read.
  always @(posedge clk) wt_done <= dsp_en & ~dsp_wr;
  assign dsp_wt    = dsp_en & ~dsp_wr & ~wt_done;
  assign dsp_rdata = {4'hA, dsp_addr};

  function automatic logic [11:0] ad(input int r, input int c);
    ad = {5'(r), 7'(c)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a byte, wait (bounded) for ready, return in the cycle after acceptance.
  task automatic send_byte(input logic [7:0] c);
    int n;
    in_valid = 1'b1;
    in_data  = c;
    n = 0;
    while (!in_ready && n < 10000) begin
      tick();
      n++;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
    tick();
  endtask

  // Write cycle check: en/wr/addr/wdata packed together.
  task automatic chk_wr(input string tag, input int r, input int c, input logic [15:0] d);
    chk(tag, {2'b0, dsp_en, dsp_wr, dsp_addr, dsp_wdata}, {4'b0011, ad(r, c), d});
  endtask

  task automatic do_clear(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 2400; i++) begin
      tick();
      if ({dsp_en, dsp_wr, dsp_addr, dsp_wdata} !== {2'b11, ad(i / 80, i % 80), 16'h0720})
        bad++;
    end
    chk(tag, bad, 0);
    tick();
    chk("clear_done_ready", {30'd0, in_ready, dsp_en}, 32'd2);
  endtask

  initial begin
    int bad;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    tick();
    tick();
    chk("reset_outs", {dsp_en, dsp_wr, in_ready, busy, dsp_addr, dsp_wdata},
        {4'b0001, 12'h000, 16'h0000});
    reset = 1'b0;
    do_clear("clear_seq");

    // 'A' then 'B' at row0.
    send_byte(8'h41);
    in_valid = 1'b0;
    chk_wr("put_A", 0, 0, 16'h0741);
    chk("ready_low_A", {31'd0, in_ready}, 32'd0);
    tick();
    chk("ready_back_A", {30'd0, in_ready, dsp_en}, 32'd2);
    send_byte(8'h42);
    in_valid = 1'b0;
    chk_wr("put_B", 0, 1, 16'h0742);

    // CR: no bus cycle, ready next cycle.
    send_byte(8'h0D);
    in_valid = 1'b0;
    chk("cr_no_bus", {31'd0, dsp_en}, 32'd0);
    tick();
    chk("cr_ready", {31'd0, in_ready}, 32'd1);

    // Stream 80 '0's with in_valid held, then '1' lands on row1 col0.
    bad = 0;
    for (int i = 0; i < 80; i++) begin
      send_byte(8'h30);
      if ({dsp_en, dsp_wr, dsp_addr, dsp_wdata} !== {2'b11, ad(0, i), 16'h0730}) bad++;
    end
    chk("stream_row0", bad, 0);
    send_byte(8'h31);
    in_valid = 1'b0;
    chk_wr("wrap_1", 1, 0, 16'h0731);

    send_byte(8'h0D);
    send_byte(8'h78);
    in_valid = 1'b0;
    chk_wr("cr_x", 1, 0, 16'h0778);
    send_byte(8'h0A);
    chk("lf_no_bus", {31'd0, dsp_en}, 32'd0);
    send_byte(8'h79);
    in_valid = 1'b0;
    chk_wr("lf_y", 2, 0, 16'h0779);

    // 27 line feeds take the cursor to row 29.
    for (int i = 0; i < 27; i++) send_byte(8'h0A);
    send_byte(8'h71);
    in_valid = 1'b0;
    chk_wr("row29_q", 29, 0, 16'h0771);

    // LF on the bottom row: scroll.
    send_byte(8'h0A);
    in_valid = 1'b0;
    chk("scroll_go", {30'd0, dsp_en, busy}, 32'd1);
    bad = 0;
    for (int r = 0; r < 29; r++) begin
      for (int c = 0; c < 80; c++) begin
        tick();
        if ({dsp_en, dsp_wr, dsp_wt, dsp_addr} !== {3'b101, ad(r + 1, c)}) bad++;
        tick();
        if ({dsp_en, dsp_wr, dsp_wt, dsp_addr} !== {3'b100, ad(r + 1, c)}) bad++;
        tick();
        if ({dsp_en, dsp_wr, dsp_addr, dsp_wdata} !== {2'b11, ad(r, c), {4'hA, ad(r + 1, c)}})
          bad++;
      end
    end
    chk("scroll_copy", bad, 0);
    bad = 0;
    for (int c = 0; c < 80; c++) begin
      tick();
      if ({dsp_en, dsp_wr, dsp_addr, dsp_wdata} !== {2'b11, ad(29, c), 16'h0720}) bad++;
    end
    chk("scroll_fill", bad, 0);
    tick();
    chk("scroll_done", {30'd0, in_ready, dsp_en}, 32'd2);
    send_byte(8'h6E);
    in_valid = 1'b0;
    chk_wr("after_scroll_n", 29, 0, 16'h076E);

    // Reset in the middle of a scroll read.
    send_byte(8'h0A);
    in_valid = 1'b0;
    tick();
    chk("mid_read_wt", {29'd0, dsp_en, dsp_wr, dsp_wt}, 32'd5);
    reset = 1'b1;
    tick();
    chk("reset_drops_en", {30'd0, dsp_en, in_ready}, 32'd0);
    reset = 1'b0;
    do_clear("reclear_seq");
    send_byte(8'h43);
    in_valid = 1'b0;
    chk_wr("cursor_home", 0, 0, 16'h0743);

    // Idle with no input.
    tick();
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ({dsp_en, in_ready, busy} !== 3'b010) bad++;
    end
    chk("idle_quiet", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/dsp_console.md
Name: dsp_console

Overview:
- Bus initiator that drives the character display's responder port (addr/en/wr/wt, 16-bit data) from a byte stream of characters.
- Keeps a text cursor and writes printable characters at the cursor as {ATTR, char} words.
- Handles CR/LF, wraps at end of line, and scrolls the screen up by reading and rewriting display memory.
- Sits between a CPU/UART-side character source and the display block.

Parameters:
ROWS, 30, visible text rows (1..32)
COLS, 80, visible text columns (1..128)
ATTR, 8'h07, attribute byte placed in data[15:8] of every write
BLANK, 8'h20, character used for clear and scroll fill

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
in_data  input  8  character byte
in_valid  input  1  in_data valid
in_ready  output  1  block accepts in_data this cycle
busy  output  1  equals ~in_ready
dsp_addr  output  12  display word address [13:2]: [13:9]=row, [8:2]=col
dsp_en  output  1  bus cycle request
dsp_wr  output  1  1=write, 0=read
dsp_wt  input  1  responder wait
dsp_wdata  output  16  write data to display
dsp_rdata  input  16  read data from display

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- All outputs are registered.
- While reset is sampled high: dsp_en=0, dsp_wr=0, dsp_addr=0, dsp_wdata=0, in_ready=0, cursor=(0,0), state=CLEAR at cell (0,0).
- Bus protocol (initiator side):
  - Write: one cycle with en=1, wr=1; dsp_wt is ignored.
  - Read: hold en=1, wr=0, addr stable until dsp_wt=0. The responder asserts wt for exactly the first cycle. Capture dsp_rdata in the cycle with wt=0, then drop en. A read costs 2 cycles.
- en=0 in every idle cycle; no back-to-back reads without en dropping.
- CLEAR state:
  - One write per cycle of {ATTR,BLANK}, row-major over rows 0..ROWS-1, cols 0..COLS-1 (ROWS*COLS cycles).
  - Then go to IDLE with cursor (0,0).
- IDLE:
  - in_ready=1, en=0.
  - Handshake occurs when in_valid && in_ready; in_data is latched and in_ready drops the next cycle.
  - in_valid without ready must be held by the source; data is not sampled.
- Character handling (decoded after acceptance):
  - 0x0D (CR): col<=0. Back to IDLE next cycle, no bus access.
  - 0x0A (LF): col<=0, row+1. If row==ROWS-1, enter SCROLL with row unchanged.
  - Any other byte: PUT state. One write cycle at (row,col) with data {ATTR,in_data}. Then col+1; if col==COLS-1, col<=0 and newline as for LF.
  - Printable, no scroll: accept cycle + write cycle, so in_ready is high again 2 cycles after acceptance.
- SCROLL:
  - For r=0..ROWS-2, c=0..COLS-1: read (r+1,c) (2 cycles), then write the captured word to (r,c) (1 cycle).
  - Then write {ATTR,BLANK} to each col of row ROWS-1 (COLS cycles), then IDLE.
  - Total 3*COLS*(ROWS-1)+COLS cycles.
  - If ROWS==1, only the blank-row fill runs.
- Counter widths: row 5 bits, col 7 bits; counters never exceed ROWS-1/COLS-1.
- Reset in any state (mid-read, mid-scroll, mid-clear) abandons the operation. en drops the cycle after reset is sampled, and CLEAR restarts from (0,0) after reset releases.
- A pending latched character is discarded on reset.

Test Plan:
- Reset 1 cycle, release:
  - Exactly 2400 write cycles (en=1, wr=1, wdata=16'h0720) over addr 0x000..(row 29, col 79).
  - Then in_ready=1.
  - No read cycles.
- After clear, send 'A' (0x41):
  - Next cycle shows one write, addr row0/col0, wdata=16'h0741.
  - in_ready low for exactly 1 cycle.
  - Then send 'B' -> write at col1.
- Hold in_valid=1 with 80 bytes 0x30 then 0x31:
  - 0x31 is written at row1/col0, proving the wrap.
  - CR then 'x' writes row1/col0; LF then 'y' writes row2/col0.
- Cursor at row29, send LF:
  - 29*80 read/write triples, each read holding en through one wt=1 cycle.
  - Each write to (r,c) carries the dsp_rdata returned from (r+1,c).
  - Then 80 writes of 16'h0720 to row29; next char is written at row29/col0.
- Assert reset during a scroll read (wt=1):
  - en=0 the next cycle.
  - After release, the full 2400-cycle clear reruns.
  - Cursor returns to (0,0).
- in_valid held low for 100 cycles in IDLE -> en stays 0, in_ready stays 1, busy stays 0.
